// File: rtl/seq_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_adder_pkg
// Purpose  : Shared types and sizing for the multi-cycle sliced adder.
// Revision : 1.0
// ============================================================================
package seq_adder_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;
    localparam int DEF_N     = DEF_WIDTH / DEF_CHUNK;

    // Keeps the slice counter at least one bit wide when N == 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_adder_chunk.sv
`default_nettype none
// ============================================================================
// Module   : chunk_adder
// Purpose  : Combinational W-bit carry-propagate slice with MSB carry-in tap.
// Revision : 1.0
// ============================================================================
module chunk_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    logic [W:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign sum    = w_full[W-1:0];
    assign cout   = w_full[W];
    // Carry into the top bit recovered from that bit's sum equation.
    assign c_msb  = w_full[W-1] ^ a[W-1] ^ b[W-1];

endmodule
`default_nettype wire

// File: rtl/seq_adder.sv
`default_nettype none
// ============================================================================
// Module   : seq_adder
// Purpose  : WIDTH-bit adder computed CHUNK bits per clock with start/done
//            handshake. Define SEQ_ADDER_SUB_EN to add the `sub` port (A-B).
// Revision : 1.0
// ============================================================================
module seq_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SEQ_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             Cout,
    output logic             Overflow
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] c_LAST = CW'(N - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_b_in;
    logic             w_cin0;
    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic [CHUNK-1:0] w_slice_sum;
    logic             w_slice_cout;
    logic             w_slice_cmsb;
    logic [WIDTH-1:0] w_sum_next;

`ifdef SEQ_ADDER_SUB_EN
    // Subtraction is A + ~B + 1: invert B at load, seed the carry with 1.
    assign w_b_in = sub ? ~B : B;
    assign w_cin0 = sub;
`else
    assign w_b_in = B;
    assign w_cin0 = 1'b0;
`endif

    assign w_run      = (r_state == S_RUN);
    assign w_accept   = !w_run && start;
    assign w_last     = w_run && (r_cnt == c_LAST);
    assign w_sum_next = {w_slice_sum, r_sum[WIDTH-1:CHUNK]};

    chunk_adder #(
        .W (CHUNK)
    ) u_chunk (
        .a     (r_a[CHUNK-1:0]),
        .b     (r_b[CHUNK-1:0]),
        .cin   (r_carry),
        .sum   (w_slice_sum),
        .cout  (w_slice_cout),
        .c_msb (w_slice_cmsb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (r_cnt == c_LAST) w_next = S_DONE;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            Result   <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
        end else if (w_accept) begin
            r_a     <= A;
            r_b     <= w_b_in;
            r_carry <= w_cin0;
            r_cnt   <= '0;
        end else if (w_run) begin
            r_a     <= r_a >> CHUNK;
            r_b     <= r_b >> CHUNK;
            r_sum   <= w_sum_next;
            r_carry <= w_slice_cout;
            r_cnt   <= r_cnt + CW'(1);
            // Visible outputs only move on the completing edge.
            if (w_last) begin
                Result   <= w_sum_next;
                Cout     <= w_slice_cout;
                Overflow <= w_slice_cout ^ w_slice_cmsb;
            end
        end
    end

    assign busy = w_run;
    assign done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_seq_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_adder
// Purpose  : Self-checking bench for seq_adder against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_seq_adder;

    logic        clk;
    logic        rst;
    logic        start;
`ifdef SEQ_ADDER_SUB_EN
    logic        sub;
`endif
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] Result;
    logic        Cout;
    logic        Overflow;

    int n_pass  = 0;
    int n_total = 0;

    seq_adder dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
`ifdef SEQ_ADDER_SUB_EN
        .sub      (sub),
`endif
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .Result   (Result),
        .Cout     (Cout),
        .Overflow (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {overflow, cout, result} using signed/unsigned integer arithmetic.
    function automatic logic [33:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic s);
        longint sa, sb, ua, ub, t;
        logic [31:0] r;
        logic        c, o;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        if (s) begin
            r = a - b;
            c = (ua >= ub);
            t = sa - sb;
        end else begin
            r = a + b;
            c = (ua + ub) >= 64'sd4294967296;
            t = sa + sb;
        end
        o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
        return {o, c, r};
    endfunction

    // Drives one operation from a post-edge point and waits (bounded) for done.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] res, output logic co, output logic ov,
                         output int nbusy, output logic held, output logic tmo);
        logic [31:0] prev;
        A = a;
        B = b;
`ifdef SEQ_ADDER_SUB_EN
        sub = s;
`endif
        start = 1'b1;
        prev  = Result;
        held  = 1'b1;
        nbusy = 0;
        tmo   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                tmo = 1'b0;
                break;
            end
            if (busy) nbusy++;
            if (Result !== prev) held = 1'b0;
            @(posedge clk); #1;
        end
        res = Result;
        co  = Cout;
        ov  = Overflow;
        if (s) begin end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        logic co, ov, held, tmo;
        int nb;
        logic seen;
        #2;
        n_total++;
        if ({busy, done, Result, Cout, Overflow} !== 35'd0)
            $display("FAIL reset_values: got busy=%b done=%b Result=%h Cout=%b Ovf=%b, want all 0",
                     busy, done, Result, Cout, Overflow);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_op(32'h5, 32'h3, 1'b0, r, co, ov, nb, held, tmo);
        // Asynchronous reset landing mid-cycle while done is high.
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({busy, done, Result, Cout, Overflow} !== 35'd0)
            $display("FAIL reset_async: got busy=%b done=%b Result=%h, want all 0",
                     busy, done, Result);
        else n_pass++;
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done || busy) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_total++;
        if (seen !== 1'b0) $display("FAIL reset_no_done: got activity=%b, want 0", seen);
        else n_pass++;
    endtask

    task automatic test_add_directed();
        logic [31:0] r;
        logic co, ov, held, tmo;
        int nb;
        logic [31:0] ta [3] = '{32'h0000_0005, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        logic [31:0] tb [3] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0001};
        logic [33:0] want [3] = '{{1'b0, 1'b0, 32'h0000_0008},
                                  {1'b0, 1'b1, 32'h0000_0000},
                                  {1'b1, 1'b0, 32'h8000_0000}};
        for (int k = 0; k < 3; k++) begin
            do_op(ta[k], tb[k], 1'b0, r, co, ov, nb, held, tmo);
            n_total++;
            if (tmo) $display("FAIL add_timeout[%0d]: got no done within bound, want done", k);
            else n_pass++;
            n_total++;
            if ({ov, co, r} !== want[k])
                $display("FAIL add_result[%0d]: got R=%h C=%b V=%b, want R=%h C=%b V=%b",
                         k, r, co, ov, want[k][31:0], want[k][32], want[k][33]);
            else n_pass++;
            n_total++;
            if (nb !== 4) $display("FAIL add_busy_cycles[%0d]: got %0d, want 4", k, nb);
            else n_pass++;
            n_total++;
            if (held !== 1'b1) $display("FAIL add_partial[%0d]: got Result change before done, want held", k);
            else n_pass++;
            @(posedge clk); #1;
            n_total++;
            if (done !== 1'b0 || r !== Result)
                $display("FAIL add_done_pulse[%0d]: got done=%b R=%h, want done=0 R=%h", k, done, Result, r);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, r;
        logic co, ov, held, tmo, s;
        int nb;
        logic [33:0] exp;
        for (int k = 0; k < 30; k++) begin
            a = $urandom;
            b = $urandom;
            if (k % 5 == 0) a[31:24] = 8'h7F;
            if (k % 7 == 0) b = ~a;
`ifdef SEQ_ADDER_SUB_EN
            s = $urandom_range(0, 1) != 0;
`else
            s = 1'b0;
`endif
            exp = ref_model(a, b, s);
            do_op(a, b, s, r, co, ov, nb, held, tmo);
            n_total++;
            if (tmo || {ov, co, r} !== exp)
                $display("FAIL random[%0d]: a=%h b=%h s=%b got R=%h C=%b V=%b to=%b, want R=%h C=%b V=%b",
                         k, a, b, s, r, co, ov, tmo, exp[31:0], exp[32], exp[33]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] first;
        logic [33:0] exp;
        int cnt;
        logic got, held;
        exp = ref_model(32'h0102_0304, 32'h00F0_0F00, 1'b0);
        A = 32'h0102_0304;
        B = 32'h00F0_0F00;
`ifdef SEQ_ADDER_SUB_EN
        sub = 1'b0;
`endif
        start = 1'b1;
        @(posedge clk); #1;
        // start stays high through RUN with different operands
        A = 32'hDEAD_BEEF;
        B = 32'h1234_5678;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        n_total++;
        if (!got || {Overflow, Cout, Result} !== exp)
            $display("FAIL b2b_first: got R=%h done=%b, want R=%h done=1", Result, got, exp[31:0]);
        else n_pass++;
        first = Result;
        A = 32'h10;
        B = 32'h20;
        held = 1'b1;
        got  = 1'b0;
        cnt  = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            cnt++;
            if (done) begin
                got = 1'b1;
                break;
            end
            if (Result !== first) held = 1'b0;
        end
        n_total++;
        if (!got || cnt !== 5)
            $display("FAIL b2b_latency: got %0d cycles done=%b, want 5 cycles", cnt, got);
        else n_pass++;
        n_total++;
        if (Result !== 32'h30) $display("FAIL b2b_result: got %h, want 00000030", Result);
        else n_pass++;
        n_total++;
        if (held !== 1'b1) $display("FAIL b2b_hold: got first Result disturbed, want held %h", first);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] r;
        logic co, ov, held, tmo, seen;
        int nb;
        A = 32'h1234_5678;
        B = 32'h1111_1111;
`ifdef SEQ_ADDER_SUB_EN
        sub = 1'b0;
`endif
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_total++;
        if (Result !== 32'd0 || busy !== 1'b0)
            $display("FAIL midrun_reset: got R=%h busy=%b, want 0/0", Result, busy);
        else n_pass++;
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done || Result !== 32'd0) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_total++;
        if (seen !== 1'b0) $display("FAIL midrun_abandon: got done/Result activity, want none");
        else n_pass++;
        do_op(32'h1234_5678, 32'h1111_1111, 1'b0, r, co, ov, nb, held, tmo);
        n_total++;
        if (tmo || r !== 32'h2345_6789)
            $display("FAIL midrun_restart: got R=%h to=%b, want 23456789", r, tmo);
        else n_pass++;
    endtask

`ifdef SEQ_ADDER_SUB_EN
    task automatic test_sub();
        logic [31:0] r;
        logic co, ov, held, tmo;
        int nb;
        do_op(32'd5, 32'd3, 1'b1, r, co, ov, nb, held, tmo);
        n_total++;
        if (tmo || r !== 32'd2 || co !== 1'b1 || ov !== 1'b0)
            $display("FAIL sub_small: got R=%h C=%b V=%b, want 00000002 1 0", r, co, ov);
        else n_pass++;
        do_op(32'h8000_0000, 32'd1, 1'b1, r, co, ov, nb, held, tmo);
        n_total++;
        if (tmo || r !== 32'h7FFF_FFFF || co !== 1'b1 || ov !== 1'b1)
            $display("FAIL sub_ovf: got R=%h C=%b V=%b, want 7fffffff 1 1", r, co, ov);
        else n_pass++;
        do_op(32'd3, 32'd5, 1'b1, r, co, ov, nb, held, tmo);
        n_total++;
        if (tmo || r !== 32'hFFFF_FFFE || co !== 1'b0)
            $display("FAIL sub_borrow: got R=%h C=%b, want fffffffe 0", r, co);
        else n_pass++;
    endtask
`endif

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
`ifdef SEQ_ADDER_SUB_EN
        sub   = 1'b0;
`endif
        test_reset();
        test_add_directed();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
`ifdef SEQ_ADDER_SUB_EN
        test_sub();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_adder.md
# seq_adder

Multi-cycle 32-bit two's-complement adder that processes one CHUNK-bit slice of the operands per clock, using a narrow carry-propagate slice instead of a full-width carry chain. Sits in the datapath ALU beside the combinational adder and subtractor. Serves timing-critical builds where a 32-bit carry path does not close. Start/busy/done handshake. Result, carry-out and signed overflow are registered and held until the next operation completes.

## Interface
- WIDTH, 32, operand/result width
- CHUNK, 8, bits added per cycle; must divide WIDTH; N = WIDTH/CHUNK cycles per operation
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous and active-high
- start  in  1  request; sampled only when idle or done
- A  in  WIDTH  operand A, sampled on the accepting edge
- B  in  WIDTH  operand B, sampled on the accepting edge
- busy  out  1  high while a sum is in progress
- done  out  1  one-cycle pulse: Result/Cout/Overflow just updated
- Result  out  WIDTH  A+B mod 2^WIDTH
- Cout  out  1  carry out of bit WIDTH-1
- Overflow  out  1  signed overflow (carry into MSB XOR carry out of MSB)

## Operation
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at an edge:
  - Latch A and B into internal shift registers.
  - Clear the carry flop and the slice counter.
  - Go to RUN.
- RUN, each edge:
  - Add the low CHUNK bits of the A and B shift registers plus the stored carry.
  - Shift the slice sum into the top of the sum register.
  - Store the slice carry and increment the counter.
- On the edge that processes slice N-1:
  - Load Result, Cout and Overflow from the final values.
  - Go to DONE.
- DONE lasts one cycle. It returns to IDLE, or to RUN if start=1, which gives back-to-back operation.
- start in RUN is ignored and not queued.
- Result, Cout and Overflow never show partial sums. They change only on the completing edge.
- Width rules: slice carry out is bit CHUNK of a (CHUNK+1)-bit sum. Overflow uses the carry into bit WIDTH-1, which the last slice reports.
- rst at any time, including mid-RUN, does all of the following:
  - Forces IDLE.
  - Clears Result, Cout, Overflow, busy and done to 0, and clears all internal registers.
  - Abandons the in-flight operation.

## Timing
- Reset values: busy=0, done=0, Result=0, Cout=0, Overflow=0.
- Accepting edge E0: busy=1 from after E0 through the end of RUN.
- Completing edge: E0+N (N=4 at defaults). After it, busy=0, done=1 for one cycle, and outputs are valid.
- Latency: start to done is N+1 cycles. Maximum throughput is one sum per N+1 cycles.
- Outputs are registered. No combinational path from inputs to outputs.

## Configuration
- SEQ_ADDER_SUB_EN defined:
  - Adds input port `sub` (1 bit), sampled with A/B.
  - When sub=1, the B shift register loads ~B and the initial carry is 1, so the block computes A-B.
  - Cout=1 means no borrow.
  - Overflow is the signed subtraction overflow.
- SEQ_ADDER_SUB_EN undefined: no `sub` port; the initial carry is always 0.

## Structure
- Package seq_adder_pkg holds:
  - The state enum (IDLE, RUN, DONE).
  - Default WIDTH and CHUNK.
  - The derived N and the counter width $clog2(N).
- Sub-module chunk_adder: combinational CHUNK-bit slice with ports a, b, cin, sum, cout, and c_msb (carry into the top bit, used for Overflow). Instantiated once.
- The top level holds the FSM, counter, shift registers and output registers.

## Test plan
- Reset: assert rst mid-cycle -> all outputs 0 immediately, state IDLE, no done pulse afterward.
- A=0x00000005, B=0x00000003, start pulse -> busy high 4 cycles, then done pulse; Result=0x00000008, Cout=0, Overflow=0.
- A=0xFFFFFFFF, B=0x00000001 -> Result=0x00000000, Cout=1, Overflow=0. A=0x7FFFFFFF, B=0x00000001 -> Result=0x80000000, Cout=0, Overflow=1.
- Start held high during RUN with new operands -> ignored. Start in the DONE cycle with A=0x10, B=0x20 -> second done pulse 5 cycles later with Result=0x30. First Result is held until then.
- rst asserted in the 2nd RUN cycle of 0x12345678+0x11111111 -> outputs stay 0, no done pulse. A new start after release yields Result=0x23456789.
- With SEQ_ADDER_SUB_EN: sub=1, A=5, B=3 -> Result=0x00000002, Cout=1. Sub=1, A=0x80000000, B=1 -> Result=0x7FFFFFFF, Overflow=1.
